// File: rtl/ex_branch_bht_if.sv
// EX-stage branch resolution bus: instruction/prediction inputs toward the resolver,
// registered resolution results, perf counters and the fetch-side BHT lookup back out.
interface ex_branch_bht_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
);
    logic              i_valid;
    logic              i_stall;
    logic              i_flush;
    logic [2:0]        i_op;
    logic [XLEN-1:0]   i_pc;
    logic [XLEN-1:0]   i_rs1;
    logic [XLEN-1:0]   i_rs2;
    logic [XLEN-1:0]   i_imm;
    logic              i_is_compr;
    logic              i_pred_taken;
    logic [XLEN-1:0]   i_pred_target;
    logic [XLEN-1:0]   i_if_pc;
    logic              o_if_pred_taken;
    logic              o_valid;
    logic [XLEN-1:0]   o_link_data;
    logic              o_taken;
    logic              o_redirect;
    logic [XLEN-1:0]   o_redirect_pc;
    logic [CNT_W-1:0]  o_branch_cnt;
    logic [CNT_W-1:0]  o_mispred_cnt;

    modport master (
        output i_valid, i_stall, i_flush, i_op, i_pc, i_rs1, i_rs2, i_imm,
               i_is_compr, i_pred_taken, i_pred_target, i_if_pc,
        input  o_if_pred_taken, o_valid, o_link_data, o_taken, o_redirect,
               o_redirect_pc, o_branch_cnt, o_mispred_cnt
    );

    modport slave (
        input  i_valid, i_stall, i_flush, i_op, i_pc, i_rs1, i_rs2, i_imm,
               i_is_compr, i_pred_taken, i_pred_target, i_if_pc,
        output o_if_pred_taken, o_valid, o_link_data, o_taken, o_redirect,
               o_redirect_pc, o_branch_cnt, o_mispred_cnt
    );
endinterface

// File: rtl/ex_branch_bht.sv
// EX-stage branch/jump resolver with a 2-bit saturating-counter BHT.
// Registers a redirect to fetch on mispredict and counts branches/mispredicts.
module ex_branch_bht #(
    parameter int         XLEN        = 64,
    parameter int         BHT_ENTRIES = 64,
    parameter logic [1:0] CTR_INIT    = 2'b01,
    parameter int         CNT_W       = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    ex_branch_bht_if.slave bus
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    typedef enum logic [2:0] {
        OP_JAL  = 3'd0,
        OP_JALR = 3'd1,
        OP_BEQ  = 3'd2,
        OP_BNE  = 3'd3,
        OP_BLT  = 3'd4,
        OP_BGE  = 3'd5,
        OP_BLTU = 3'd6,
        OP_BGEU = 3'd7
    } op_e;

    op_e              op;
    logic             is_jump;
    logic             is_bxx;
    logic             accept;
    logic             taken;
    logic             mispredict;
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  fallthrough;
    logic [XLEN-1:0]  redirect_pc_d;
    logic [XLEN-1:0]  link_d;
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] lkp_idx;

    logic [1:0]       bht [BHT_ENTRIES];

    logic             valid_q;
    logic             taken_q;
    logic             redirect_q;
    logic [XLEN-1:0]  link_q;
    logic [XLEN-1:0]  redirect_pc_q;
    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] mispred_cnt_q;

    logic             unused_if_pc_bits;

    assign upd_idx = bus.i_pc[IDX_W:1];
    assign lkp_idx = bus.i_if_pc[IDX_W:1];
    assign unused_if_pc_bits = ^{bus.i_if_pc[XLEN-1:IDX_W+1], bus.i_if_pc[0]};

    always_comb begin
        op          = op_e'(bus.i_op);
        is_jump     = (op == OP_JAL) || (op == OP_JALR);
        is_bxx      = ~is_jump;
        accept      = bus.i_valid & ~bus.i_stall & ~bus.i_flush;
        fallthrough = bus.i_pc + (bus.i_is_compr ? XLEN'(2) : XLEN'(4));
        if (op == OP_JALR) begin
            target = (bus.i_rs1 + bus.i_imm) & ~XLEN'(1);
        end else begin
            target = bus.i_pc + (bus.i_imm << 1);
        end
        case (op)
            OP_BEQ:  taken = (bus.i_rs1 == bus.i_rs2);
            OP_BNE:  taken = (bus.i_rs1 != bus.i_rs2);
            OP_BLT:  taken = ($signed(bus.i_rs1) <  $signed(bus.i_rs2));
            OP_BGE:  taken = ($signed(bus.i_rs1) >= $signed(bus.i_rs2));
            OP_BLTU: taken = (bus.i_rs1 <  bus.i_rs2);
            OP_BGEU: taken = (bus.i_rs1 >= bus.i_rs2);
            default: taken = 1'b1;
        endcase
        mispredict    = (taken != bus.i_pred_taken) | (taken & (target != bus.i_pred_target));
        redirect_pc_d = taken ? target : fallthrough;
        link_d        = is_jump ? fallthrough : '0;
    end

    // Reads the pre-edge counter, so a same-index update this cycle is not visible yet.
    assign bus.o_if_pred_taken = bht[lkp_idx][1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= CTR_INIT;
            end
        end else if (accept && is_bxx) begin
            if (taken) begin
                if (bht[upd_idx] != 2'b11) bht[upd_idx] <= bht[upd_idx] + 2'd1;
            end else begin
                if (bht[upd_idx] != 2'b00) bht[upd_idx] <= bht[upd_idx] - 2'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q       <= 1'b0;
            taken_q       <= 1'b0;
            redirect_q    <= 1'b0;
            link_q        <= '0;
            redirect_pc_q <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else if (!bus.i_stall) begin
            valid_q    <= accept;
            redirect_q <= accept & mispredict;
            if (accept) begin
                taken_q       <= taken;
                link_q        <= link_d;
                redirect_pc_q <= redirect_pc_d;
                if (is_bxx)     branch_cnt_q  <= branch_cnt_q + CNT_W'(1);
                if (mispredict) mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.o_valid       = valid_q;
    assign bus.o_taken       = taken_q;
    assign bus.o_redirect    = redirect_q;
    assign bus.o_link_data   = link_q;
    assign bus.o_redirect_pc = redirect_pc_q;
    assign bus.o_branch_cnt  = branch_cnt_q;
    assign bus.o_mispred_cnt = mispred_cnt_q;
endmodule

// File: tb/tb_ex_branch_bht.sv
// Bench for ex_branch_bht: directed vector table, hand-written BHT/stall/reset sequences,
// and randomized traffic against a behavioural model of branch resolution and the BHT.
module tb_ex_branch_bht;
    localparam int XLEN  = 64;
    localparam int N     = 16;
    localparam int CNT_W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ex_branch_bht_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bif ();

    ex_branch_bht #(
        .XLEN(XLEN), .BHT_ENTRIES(N), .CTR_INIT(2'b01), .CNT_W(CNT_W)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bif)
    );

    int checks   = 0;
    int failures = 0;

    int              m_ctr [N];
    int              m_bcnt, m_mcnt;
    logic            m_valid, m_taken, m_redirect;
    logic [63:0]     m_link, m_rpc;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] pc, rs1, rs2, imm;
        logic        compr, pt;
        logic [63:0] ptg;
        logic        e_taken, e_redir;
        logic [63:0] e_rpc, e_link;
    } vec_t;
    vec_t vt [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [63:0] pc);
        return int'((pc >> 1) % 64'(N));
    endfunction

    function automatic bit f_taken(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            3'd2: return a == b;
            3'd3: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [63:0] f_target(input logic [2:0] op, input logic [63:0] pc,
                                             input logic [63:0] rs1, input logic [63:0] imm);
        if (op == 3'd1) return (rs1 + imm) & ~64'd1;
        return pc + imm * 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_ctr[i] = 1;
        m_bcnt = 0; m_mcnt = 0;
        m_valid = 0; m_taken = 0; m_redirect = 0; m_link = '0; m_rpc = '0;
    endtask

    task automatic model_step();
        bit          acc, t, mis;
        logic [63:0] tg, ft;
        int          k;
        if (bif.i_stall) return;
        acc = bif.i_valid && !bif.i_flush;
        m_valid = acc;
        m_redirect = 0;
        if (!acc) return;
        t   = f_taken(bif.i_op, bif.i_rs1, bif.i_rs2);
        tg  = f_target(bif.i_op, bif.i_pc, bif.i_rs1, bif.i_imm);
        ft  = bif.i_pc + (bif.i_is_compr ? 64'd2 : 64'd4);
        mis = (t != bif.i_pred_taken) || (t && tg != bif.i_pred_target);
        m_taken = t;
        m_link = (bif.i_op <= 3'd1) ? ft : 64'd0;
        m_rpc = t ? tg : ft;
        m_redirect = mis;
        if (mis) m_mcnt++;
        if (bif.i_op >= 3'd2) begin
            m_bcnt++;
            k = idx_of(bif.i_pc);
            if (t) m_ctr[k] = (m_ctr[k] < 3) ? m_ctr[k] + 1 : 3;
            else   m_ctr[k] = (m_ctr[k] > 0) ? m_ctr[k] - 1 : 0;
        end
    endtask

    task automatic check_regs();
        chk("o_valid", 64'(bif.o_valid), 64'(m_valid));
        chk("o_taken", 64'(bif.o_taken), 64'(m_taken));
        chk("o_redirect", 64'(bif.o_redirect), 64'(m_redirect));
        chk("o_link_data", bif.o_link_data, m_link);
        chk("o_redirect_pc", bif.o_redirect_pc, m_rpc);
        chk("o_branch_cnt", 64'(bif.o_branch_cnt), 64'(m_bcnt % (1 << CNT_W)));
        chk("o_mispred_cnt", 64'(bif.o_mispred_cnt), 64'(m_mcnt % (1 << CNT_W)));
    endtask

    task automatic drive(input logic v, st, fl, input logic [2:0] op, input logic [63:0] pc, rs1, rs2, imm,
                         input logic compr, pt, input logic [63:0] ptg, ifpc);
        bif.i_valid = v; bif.i_stall = st; bif.i_flush = fl; bif.i_op = op;
        bif.i_pc = pc; bif.i_rs1 = rs1; bif.i_rs2 = rs2; bif.i_imm = imm;
        bif.i_is_compr = compr; bif.i_pred_taken = pt; bif.i_pred_target = ptg; bif.i_if_pc = ifpc;
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic tick();
        #1;
        chk("o_if_pred_taken", 64'(bif.o_if_pred_taken), 64'(m_ctr[idx_of(bif.i_if_pc)] >= 2));
        model_step();
        @(posedge clk);
        #1;
        check_regs();
        @(negedge clk);
    endtask

    task automatic lookup_chk(input string name, input logic [63:0] ifpc, input logic exp);
        bif.i_if_pc = ifpc;
        #1;
        chk(name, 64'(bif.o_if_pred_taken), 64'(exp));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 3'd0, '0, '0, '0, '0, 0, 0, '0, '0);
        model_reset();
        #2;
        check_regs();
        lookup_chk("reset_lookup_0", 64'h0, 1'b0);
        lookup_chk("reset_lookup_100", 64'h100, 1'b0);
        lookup_chk("reset_lookup_1e", 64'h1e, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  op;
        logic [63:0] pc, rs1, rs2, imm, ptg;
        logic        pt;

        vt[0]  = '{3'd2, 64'h100, 64'd5, 64'd5, 64'h8, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 64'h110, 64'h0};
        vt[1]  = '{3'd1, 64'h40, 64'h2001, 64'h0, 64'h10, 1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 64'h2010, 64'h42};
        vt[2]  = '{3'd4, 64'h200, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h20, 1'b0, 1'b1, 64'h240, 1'b1, 1'b0, 64'h240, 64'h0};
        vt[3]  = '{3'd6, 64'h200, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h20, 1'b0, 1'b1, 64'h240, 1'b0, 1'b1, 64'h204, 64'h0};
        vt[4]  = '{3'd3, 64'h300, 64'd3, 64'd3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h304, 64'h0};
        vt[5]  = '{3'd5, 64'h300, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 64'h2F8, 64'h0};
        vt[6]  = '{3'd7, 64'h1000, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h1004, 64'h0};
        vt[7]  = '{3'd0, 64'h80, 64'h0, 64'h0, 64'h100, 1'b0, 1'b1, 64'h280, 1'b1, 1'b0, 64'h280, 64'h84};
        vt[8]  = '{3'd0, 64'h80, 64'h0, 64'h0, 64'h100, 1'b0, 1'b1, 64'h284, 1'b1, 1'b1, 64'h280, 64'h84};
        vt[9]  = '{3'd2, 64'hFFFF_FFFF_FFFF_FFF0, 64'd7, 64'd7, 64'h10, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 64'h10, 64'h0};
        vt[10] = '{3'd1, 64'h600, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h2, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0, 64'h0, 64'h604};
        vt[11] = '{3'd4, 64'h500, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h4, 1'b0, 1'b1, 64'h508, 1'b1, 1'b0, 64'h508, 64'h0};

        #1;
        do_reset();

        for (int i = 0; i < 12; i++) begin
            drive(1, 0, 0, vt[i].op, vt[i].pc, vt[i].rs1, vt[i].rs2, vt[i].imm,
                  vt[i].compr, vt[i].pt, vt[i].ptg, vt[i].pc);
            tick();
            chk($sformatf("vec%0d_taken", i), 64'(bif.o_taken), 64'(vt[i].e_taken));
            chk($sformatf("vec%0d_redirect", i), 64'(bif.o_redirect), 64'(vt[i].e_redir));
            chk($sformatf("vec%0d_redirect_pc", i), bif.o_redirect_pc, vt[i].e_rpc);
            chk($sformatf("vec%0d_link", i), bif.o_link_data, vt[i].e_link);
        end

        // Counter training and saturation on a single entry.
        do_reset();
        drive(1, 0, 0, 3'd2, 64'h100, 64'd5, 64'd5, 64'h8, 0, 0, 64'h0, 64'h100);
        tick();
        chk("beq_first_bcnt", 64'(bif.o_branch_cnt), 64'd1);
        chk("beq_first_mcnt", 64'(bif.o_mispred_cnt), 64'd1);
        lookup_chk("train_pred_1", 64'h100, 1'b1);
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 3'd2, 64'h100, 64'd5, 64'd5, 64'h8, 0, 0, 64'h0, 64'h100);
            tick();
            lookup_chk($sformatf("train_pred_%0d", i + 2), 64'h100, 1'b1);
        end
        drive(1, 0, 0, 3'd2, 64'h100, 64'd5, 64'd5, 64'h8, 0, 1, 64'h110, 64'h100);
        tick();
        chk("correct_pred_no_redirect", 64'(bif.o_redirect), 64'd0);
        drive(1, 0, 0, 3'd1, 64'h100, 64'h2001, 64'd0, 64'h10, 1, 0, 64'h0, 64'h100);
        tick();
        chk("jalr_bcnt_unchanged", 64'(bif.o_branch_cnt), 64'd4);
        drive(1, 0, 0, 3'd2, 64'h100, 64'd5, 64'd6, 64'h8, 0, 1, 64'h110, 64'h100);
        tick();
        lookup_chk("sat_hold_pred", 64'h100, 1'b1);
        drive(1, 0, 0, 3'd2, 64'h100, 64'd5, 64'd6, 64'h8, 0, 1, 64'h110, 64'h100);
        tick();
        lookup_chk("untrain_pred", 64'h100, 1'b0);

        // Flush, stall hold, and async reset during a held redirect.
        do_reset();
        drive(1, 0, 1, 3'd2, 64'h100, 64'd5, 64'd5, 64'h8, 0, 0, 64'h0, 64'h100);
        tick();
        chk("flush_no_valid", 64'(bif.o_valid), 64'd0);
        chk("flush_no_count", 64'(bif.o_branch_cnt), 64'd0);
        lookup_chk("flush_no_train", 64'h100, 1'b0);
        drive(1, 0, 0, 3'd2, 64'h100, 64'd5, 64'd5, 64'h8, 0, 0, 64'h0, 64'h100);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 3'd3, 64'h100, 64'd1, 64'd2, 64'h40, 0, 0, 64'h0, 64'h100);
            tick();
            chk($sformatf("stall%0d_redirect_held", i), 64'(bif.o_redirect), 64'd1);
            chk($sformatf("stall%0d_rpc_held", i), bif.o_redirect_pc, 64'h110);
            chk($sformatf("stall%0d_bcnt_held", i), 64'(bif.o_branch_cnt), 64'd1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_redirect", 64'(bif.o_redirect), 64'd0);
        chk("async_reset_valid", 64'(bif.o_valid), 64'd0);
        chk("async_reset_mcnt", 64'(bif.o_mispred_cnt), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 3'd0, '0, '0, '0, '0, 0, 0, '0, '0);
        tick();

        // Randomized traffic; small PC range for BHT aliasing, enough Bxx to wrap 8-bit counters.
        for (int i = 0; i < 1200; i++) begin
            op  = 3'($urandom_range(0, 7));
            pc  = 64'($urandom_range(0, 127)) << 1;
            if ($urandom_range(0, 9) == 0) pc = {$urandom, $urandom} & ~64'd1;
            rs1 = 64'(longint'($urandom_range(0, 6)) - 3);
            rs2 = 64'(longint'($urandom_range(0, 6)) - 3);
            if ($urandom_range(0, 7) == 0) rs1 = {$urandom, $urandom};
            imm = 64'(longint'($urandom_range(0, 64)) - 32);
            pt  = 1'($urandom_range(0, 1));
            ptg = ($urandom_range(0, 1) == 1) ? f_target(op, pc, rs1, imm) : 64'($urandom_range(0, 511));
            drive($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10,
                  op, pc, rs1, rs2, imm, 1'($urandom_range(0, 1)), pt, ptg,
                  64'($urandom_range(0, 255)) << 1);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
